// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the matrix-multiply ALU.
//   WIDTH_DEF   default datapath width
//   OP_*        operation codes driven by the control unit
//   state_e     ALU sequencer states
package alu_pkg;

  localparam int WIDTH_DEF = 19;

  localparam logic [2:0] OP_PASSA = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_SUB   = 3'b010;
  localparam logic [2:0] OP_MUL   = 3'b011;
  localparam logic [2:0] OP_INCA  = 3'b100;
  localparam logic [2:0] OP_DECA  = 3'b101;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MUL_RUN = 1'b1
  } state_e;

endpackage

// File: rtl/alu_core_if.sv
// alu_core_if: issue/result bus between the control unit and the ALU.
//   master: control side, drives start/op/alu_a/alu_b, observes results
//   slave : ALU side, drives result/z_flag/c_flag/busy/done
interface alu_core_if #(
  parameter int WIDTH = alu_pkg::WIDTH_DEF
) ();

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] result;
  logic             z_flag;
  logic             c_flag;
  logic             busy;
  logic             done;

  modport master (
    output start, op, alu_a, alu_b,
    input  result, z_flag, c_flag, busy, done
  );

  modport slave (
    input  start, op, alu_a, alu_b,
    output result, z_flag, c_flag, busy, done
  );

endinterface

// File: rtl/alu_core_seq_multiplier.sv
// seq_multiplier: iterative unsigned shift-add multiplier datapath.
//   clk, rst   clock, async active-high reset
//   load_i     capture operands, clear accumulator and counter
//   step_i     perform one shift-add iteration
//   a_i, b_i   multiplicand / multiplier
//   prod_o     accumulator value including the current iteration
//   last_o     current iteration is the final one
module seq_multiplier #(
  parameter int WIDTH = 19
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] prod_o,
  output logic               last_o
);

  localparam logic [4:0] LAST_CNT = 5'(WIDTH - 1);

  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplr_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [4:0]         cnt_q;

  // The product output already includes the add of the current step so the
  // owner can register the final value on the same edge as the last step.
  always_comb begin
    acc_d = acc_q;
    if (mplr_q[0]) begin
      acc_d = acc_q + mcand_q;
    end
  end

  assign prod_o = acc_d;
  assign last_o = (cnt_q == LAST_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else if (load_i) begin
      mcand_q <= {{WIDTH{1'b0}}, a_i};
      mplr_q  <= b_i;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else if (step_i) begin
      acc_q   <= acc_d;
      mcand_q <= mcand_q << 1;
      mplr_q  <= mplr_q >> 1;
      cnt_q   <= cnt_q + 5'd1;
    end
  end

endmodule

// File: rtl/alu_core.sv
// alu_core: sequential ALU for the matrix-multiply datapath.
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  alu_core_if.slave: start/op/alu_a/alu_b in;
//        result/z_flag/c_flag/busy/done out (all registered)
// Single-cycle ops complete at the accepting edge; MUL runs WIDTH iterations
// in seq_multiplier while busy is high.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic       clk,
  input  logic       rst,
  alu_core_if.slave  bus
);

  state_e             state_q;
  logic [WIDTH-1:0]   result_q;
  logic               z_q;
  logic               c_q;
  logic               busy_q;
  logic               done_q;

  logic [WIDTH-1:0]   res_d;
  logic               c_d;
  logic [WIDTH:0]     ext_d;

  logic               accept_w;
  logic               mul_load_w;
  logic               mul_step_w;
  logic [2*WIDTH-1:0] mul_prod_w;
  logic               mul_last_w;
  logic [WIDTH-1:0]   mul_res_w;

  assign accept_w   = (state_q == ST_IDLE) && bus.start;
  assign mul_load_w = accept_w && (bus.op == OP_MUL);
  assign mul_step_w = (state_q == ST_MUL_RUN);
  assign mul_res_w  = mul_prod_w[WIDTH-1:0];

  // Single-cycle ops; the extra top bit of ext_d is carry for adds and
  // borrow for subtracts (unsigned wraparound sets it).
  always_comb begin
    res_d = '0;
    c_d   = 1'b0;
    ext_d = '0;
    case (bus.op)
      OP_PASSA: res_d = bus.alu_a;
      OP_ADD: begin
        ext_d = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        res_d = ext_d[WIDTH-1:0];
        c_d   = ext_d[WIDTH];
      end
      OP_SUB: begin
        ext_d = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
        res_d = ext_d[WIDTH-1:0];
        c_d   = ext_d[WIDTH];
      end
      OP_INCA: begin
        ext_d = {1'b0, bus.alu_a} + {{WIDTH{1'b0}}, 1'b1};
        res_d = ext_d[WIDTH-1:0];
        c_d   = ext_d[WIDTH];
      end
      OP_DECA: begin
        ext_d = {1'b0, bus.alu_a} - {{WIDTH{1'b0}}, 1'b1};
        res_d = ext_d[WIDTH-1:0];
        c_d   = ext_d[WIDTH];
      end
      default: begin
        res_d = '0;
        c_d   = 1'b0;
      end
    endcase
  end

  seq_multiplier #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .load_i (mul_load_w),
    .step_i (mul_step_w),
    .a_i    (bus.alu_a),
    .b_i    (bus.alu_b),
    .prod_o (mul_prod_w),
    .last_o (mul_last_w)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept_w) begin
            if (bus.op == OP_MUL) begin
              busy_q  <= 1'b1;
              state_q <= ST_MUL_RUN;
            end else begin
              result_q <= res_d;
              z_q      <= (res_d == '0);
              c_q      <= c_d;
              done_q   <= 1'b1;
            end
          end
        end
        ST_MUL_RUN: begin
          // start is ignored here; only the iteration counter ends the run.
          if (mul_last_w) begin
            result_q <= mul_res_w;
            z_q      <= (mul_res_w == '0);
            c_q      <= |mul_prod_w[2*WIDTH-1:WIDTH];
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.result = result_q;
  assign bus.z_flag = z_q;
  assign bus.c_flag = c_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule
